// File: rtl/reg_file_pkg.sv
// Shared register-file constants and types, also imported by the ALU and the writeback mux.
package reg_file_pkg;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] reg_word_t;
endpackage

// File: rtl/register_32.sv
// Single architectural register with synchronous reset and write enable.
module register_32 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] data_q;
    logic [W-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (en) data_d = d;
    end

    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/reg_file.sv
// Architectural register file: r0 hardwired to zero, overflow-trapped writes are dropped
// and flagged in a sticky bit. Define REG_FILE_BYPASS_EN for same-cycle write-to-read forwarding.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs_a,
    input  logic [ADDR_W-1:0] rs_b,
    input  logic [ADDR_W-1:0] rd,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_of,
    input  logic              of_trap,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] bus_a,
    output logic [DATA_W-1:0] bus_b,
    output logic              ovf_sticky
);
    localparam int                NREGS    = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              wr_suppress;
    logic              wr_commit;
    logic              ovf_sticky_q;
    logic              ovf_sticky_d;

    assign wr_suppress = wr_en & of_trap & wr_of;
    assign wr_commit   = wr_en & (rd != ZERO_IDX) & ~(of_trap & wr_of);

    assign regs_q[0] = '0;

    for (genvar i = 1; i < NREGS; i++) begin : g_regs
        register_32 #(.W(DATA_W)) u_reg (
            .clk (clk),
            .rst (rst),
            .en  (wr_commit && (rd == ADDR_W'(i))),
            .d   (wr_data),
            .q   (regs_q[i])
        );
    end

    // A suppressed write on the same edge as a clear leaves the flag set.
    always_comb begin
        ovf_sticky_d = ovf_sticky_q;
        if (wr_suppress)  ovf_sticky_d = 1'b1;
        else if (ovf_clr) ovf_sticky_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) ovf_sticky_q <= 1'b0;
        else     ovf_sticky_q <= ovf_sticky_d;
    end

    assign ovf_sticky = ovf_sticky_q;

    always_comb begin
        bus_a = regs_q[rs_a];
        bus_b = regs_q[rs_b];
`ifdef REG_FILE_BYPASS_EN
        // wr_commit already excludes r0 and trapped writes, so neither can forward.
        if (wr_commit && (rs_a == rd)) bus_a = wr_data;
        if (wr_commit && (rs_b == rd)) bus_b = wr_data;
`endif
    end
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;
    logic        clk;
    logic        rst;
    logic [4:0]  rs_a, rs_b, rd;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        wr_of, of_trap, ovf_clr;
    logic [31:0] bus_a, bus_b;
    logic        ovf_sticky;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    logic        msticky;

    reg_file dut (
        .clk        (clk),
        .rst        (rst),
        .rs_a       (rs_a),
        .rs_b       (rs_b),
        .rd         (rd),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_of      (wr_of),
        .of_trap    (of_trap),
        .ovf_clr    (ovf_clr),
        .bus_a      (bus_a),
        .bus_b      (bus_b),
        .ovf_sticky (ovf_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, applying the architectural rules to the model first.
    task automatic tick();
        bit trapped;
        trapped = wr_en && of_trap && wr_of;
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            msticky = 1'b0;
        end else begin
            if (wr_en && !trapped && rd != 5'd0) model[rd] = wr_data;
            if (trapped)      msticky = 1'b1;
            else if (ovf_clr) msticky = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 0; wr_en = 0; wr_data = 0; wr_of = 0; of_trap = 0; ovf_clr = 0; rd = 0;
    endtask

    task automatic write(input logic [4:0] r, input logic [31:0] v);
        idle();
        wr_en = 1; rd = r; wr_data = v;
        tick();
        idle();
    endtask

    // Value a bus should show right now, before the coming edge.
    function automatic logic [31:0] exp_bus(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (wr_en && !(of_trap && wr_of) && rd == idx) return wr_data;
`endif
        return model[idx];
    endfunction

    task automatic test_reset();
        write(5'd5, 32'hDEADBEEF);
        rs_a = 5; #2;
        checks++;
        if (bus_a !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_r5 got %h want %h", bus_a, 32'hDEADBEEF); end
        // reset cycle also carries a write that must be lost
        idle(); rst = 1; wr_en = 1; rd = 6; wr_data = 32'h55;
        tick();
        idle(); rs_a = 5; rs_b = 6; #2;
        checks++;
        if (bus_a !== 32'h0) begin errors++; $display("FAIL reset_r5 got %h want %h", bus_a, 32'h0); end
        checks++;
        if (bus_b !== 32'h0) begin errors++; $display("FAIL reset_lost_write got %h want %h", bus_b, 32'h0); end
        checks++;
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL reset_sticky got %b want 0", ovf_sticky); end
    endtask

    task automatic test_basic();
        write(5'd7, 32'h12345678);
        rs_a = 7; rs_b = 7; #2;
        checks++;
        if (bus_a !== 32'h12345678) begin errors++; $display("FAIL basic_a got %h want %h", bus_a, 32'h12345678); end
        checks++;
        if (bus_b !== 32'h12345678) begin errors++; $display("FAIL basic_b got %h want %h", bus_b, 32'h12345678); end
    endtask

    task automatic test_zero_reg();
        idle(); wr_en = 1; rd = 0; wr_data = 32'hFFFFFFFF; rs_a = 0; rs_b = 0; #2;
        checks++;
        if (bus_a !== 32'h0) begin errors++; $display("FAIL zero_same_cycle got %h want %h", bus_a, 32'h0); end
        tick();
        idle(); #2;
        checks++;
        if (bus_b !== 32'h0) begin errors++; $display("FAIL zero_after got %h want %h", bus_b, 32'h0); end
    endtask

    task automatic test_overflow();
        write(5'd3, 32'h1);
        idle(); wr_en = 1; rd = 3; wr_data = 32'h80000000; wr_of = 1; of_trap = 1;
        tick();
        idle(); rs_a = 3; #2;
        checks++;
        if (bus_a !== 32'h1) begin errors++; $display("FAIL trap_keeps_r3 got %h want %h", bus_a, 32'h1); end
        checks++;
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL trap_sets_sticky got %b want 1", ovf_sticky); end
        idle(); wr_en = 1; rd = 3; wr_data = 32'h80000000; wr_of = 1; of_trap = 0;
        tick();
        idle(); rs_a = 3; #2;
        checks++;
        if (bus_a !== 32'h80000000) begin errors++; $display("FAIL unsigned_write got %h want %h", bus_a, 32'h80000000); end
        checks++;
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL unsigned_sticky got %b want 1", ovf_sticky); end
    endtask

    task automatic test_sticky_collision();
        idle(); ovf_clr = 1;
        tick();
        idle(); #2;
        checks++;
        if (ovf_sticky !== 1'b0) begin errors++; $display("FAIL sticky_clear got %b want 0", ovf_sticky); end
        // clear together with a trapped write to r0: set wins, r0 stays zero
        idle(); ovf_clr = 1; wr_en = 1; rd = 0; wr_data = 32'h7; wr_of = 1; of_trap = 1;
        tick();
        idle(); rs_a = 0; #2;
        checks++;
        if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL set_beats_clear got %b want 1", ovf_sticky); end
        checks++;
        if (bus_a !== 32'h0) begin errors++; $display("FAIL trap_r0 got %h want %h", bus_a, 32'h0); end
    endtask

    task automatic test_bypass();
        logic [31:0] want_now;
`ifdef REG_FILE_BYPASS_EN
        want_now = 32'hCAFEF00D;
`else
        want_now = 32'h0;
`endif
        idle(); wr_en = 1; rd = 9; wr_data = 32'hCAFEF00D; rs_a = 9; rs_b = 9; #2;
        checks++;
        if (bus_a !== want_now) begin errors++; $display("FAIL bypass_same_a got %h want %h", bus_a, want_now); end
        checks++;
        if (bus_b !== want_now) begin errors++; $display("FAIL bypass_same_b got %h want %h", bus_b, want_now); end
        tick();
        idle(); #2;
        checks++;
        if (bus_a !== 32'hCAFEF00D) begin errors++; $display("FAIL bypass_next got %h want %h", bus_a, 32'hCAFEF00D); end
        // a trapped write must never forward
        idle(); wr_en = 1; rd = 9; wr_data = 32'h11111111; wr_of = 1; of_trap = 1; #2;
        checks++;
        if (bus_a !== 32'hCAFEF00D) begin errors++; $display("FAIL trap_no_bypass got %h want %h", bus_a, 32'hCAFEF00D); end
        tick();
        idle();
    endtask

    task automatic test_back_to_back();
        idle(); wr_en = 1; rd = 10; wr_data = 32'hA5A5A5A5;
        tick();
        wr_en = 1; rd = 11; wr_data = 32'h5A5A5A5A;
        tick();
        idle(); rs_a = 10; rs_b = 11; #2;
        checks++;
        if (bus_a !== 32'hA5A5A5A5) begin errors++; $display("FAIL b2b_r10 got %h want %h", bus_a, 32'hA5A5A5A5); end
        checks++;
        if (bus_b !== 32'h5A5A5A5A) begin errors++; $display("FAIL b2b_r11 got %h want %h", bus_b, 32'h5A5A5A5A); end
    endtask

    task automatic test_random();
        logic [31:0] ea, eb;
        for (int n = 0; n < 400; n++) begin
            rst     = ($urandom_range(0, 39) == 0);
            wr_en   = $urandom_range(0, 3) != 0;
            rd      = 5'($urandom_range(0, 31));
            wr_data = $urandom;
            of_trap = $urandom_range(0, 1) != 0;
            wr_of   = ($urandom_range(0, 3) == 0);
            ovf_clr = ($urandom_range(0, 7) == 0);
            rs_a    = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs_b    = ($urandom_range(0, 3) == 0) ? rs_a : 5'($urandom_range(0, 31));
            #2;
            ea = exp_bus(rs_a);
            eb = exp_bus(rs_b);
            checks++;
            if (bus_a !== ea) begin errors++; $display("FAIL rand_bus_a[%0d] rs=%0d got %h want %h", n, rs_a, bus_a, ea); end
            checks++;
            if (bus_b !== eb) begin errors++; $display("FAIL rand_bus_b[%0d] rs=%0d got %h want %h", n, rs_b, bus_b, eb); end
            checks++;
            if (ovf_sticky !== msticky) begin errors++; $display("FAIL rand_sticky[%0d] got %b want %b", n, ovf_sticky, msticky); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle(); rs_a = 0; rs_b = 0;
        rst = 1;
        tick();
        tick();
        idle();
        test_reset();
        test_basic();
        test_zero_reg();
        test_overflow();
        test_sticky_collision();
        test_bypass();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
